// File: rtl/fft_pkg.sv
// Shared FFT types and default sizes used by the FFT core and its downstream consumers.
package fft_pkg;

   localparam int DEF_BIT_WIDTH = 16;
   localparam int DEF_M         = 9;
   localparam int DEF_N         = 512;

   typedef struct packed {
      logic signed [DEF_BIT_WIDTH-1:0] re;
      logic signed [DEF_BIT_WIDTH-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_REPORT
   } peak_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Registered squared magnitude re^2 + im^2 of one complex bin, with its valid bit.
module fft_mag_sq
   import fft_pkg::*;
#(
   parameter int bit_width = DEF_BIT_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [bit_width-1:0] re_p1,
   input  logic signed [bit_width-1:0] im_p1,
   input  logic                        vld_p1,
   output logic [2*bit_width-1:0]      mag_p2,
   output logic                        vld_p2
);

   localparam int MW = 2*bit_width;

   // Each square is at most 2^(2*bit_width-2), so the sum never overflows MW bits.
   function automatic logic [MW-1:0] square(input logic signed [bit_width-1:0] x);
      logic signed [MW-1:0] xe;
      xe = MW'(x);
      return $unsigned(xe * xe);
   endfunction

   logic [MW-1:0] mag_p2_d, mag_p2_q;
   logic          vld_p2_d, vld_p2_q;

   always_comb begin
      mag_p2_d = square(re_p1) + square(im_p1);
      vld_p2_d = vld_p1;
   end

   // stage 1 -> stage 2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_p2_q <= 1'b0;
      else        vld_p2_q <= vld_p2_d;
   end

   always_ff @(posedge clk) begin
      mag_p2_q <= mag_p2_d;
   end

   assign mag_p2 = mag_p2_q;
   assign vld_p2 = vld_p2_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Sweeps the positive-frequency half of the FFT result RAM after each frame and
// reports the bin with the largest squared magnitude.
module fft_peak_detect
   import fft_pkg::*;
#(
   parameter int                   bit_width = DEF_BIT_WIDTH,
   parameter int                   M         = DEF_M,
   parameter int                   N         = DEF_N,
   parameter int                   MIN_BIN   = 1,
   parameter logic [2*bit_width-1:0] THRESH  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fft_done,
   output logic [M-1:0]           rd_adr,
   input  logic [2*bit_width-1:0] wd,
   output logic                   busy,
   output logic                   peak_valid,
   output logic [M-1:0]           peak_bin,
   output logic [2*bit_width-1:0] peak_mag,
   output logic                   no_signal
);

   localparam int           MW        = 2*bit_width;
   localparam logic [M-1:0] FIRST_BIN = M'(MIN_BIN);
   localparam logic [M-1:0] LAST_BIN  = M'(N/2 - 1);
   localparam logic [M-1:0] ADR_ONE   = M'(1);

   // Widened subtraction keeps the comparison meaningful even when THRESH is 0.
   function automatic logic below_thresh(input logic [MW-1:0] m);
      logic [MW:0] diff;
      diff = {1'b0, m} - {1'b0, THRESH};
      return diff[MW];
   endfunction

   peak_state_t   state_q, state_d;
   logic          done_q;
   logic          drain_q, drain_d;
   logic [M-1:0]  adr_q, adr_d;
   logic          scan_start, vld_p0, report;

   logic          vld_p1_q;
   logic [M-1:0]  bin_p1_q, bin_p2_q;
   logic signed [bit_width-1:0] re_p1, im_p1;
   logic [MW-1:0] mag_p2;
   logic          vld_p2;

   logic [MW-1:0] best_mag_q, best_mag_d;
   logic [M-1:0]  best_bin_q, best_bin_d;
   logic          peak_valid_q, peak_valid_d;
   logic [M-1:0]  peak_bin_q, peak_bin_d;
   logic [MW-1:0] peak_mag_q, peak_mag_d;
   logic          no_signal_q, no_signal_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         drain_q <= 1'b0;
         adr_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= fft_done;
         drain_q <= drain_d;
         adr_q   <= adr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      adr_d   = adr_q;
      unique case (state_q)
         ST_IDLE: begin
            adr_d = '0;
            if (fft_done && !done_q) begin
               state_d = ST_SCAN;
               adr_d   = FIRST_BIN;
            end
         end
         ST_SCAN: begin
            if (adr_q == LAST_BIN) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end else begin
               adr_d = adr_q + ADR_ONE;
            end
         end
         ST_DRAIN: begin
            if (drain_q) state_d = ST_REPORT;
            else         drain_d = 1'b1;
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
            adr_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      vld_p0     = (state_q == ST_SCAN);
      report     = (state_q == ST_REPORT);
      scan_start = (state_q == ST_IDLE) && fft_done && !done_q;
   end

   // stage 0 -> stage 1: the RAM returns wd for the address issued one cycle earlier
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_p1_q <= 1'b0;
      else        vld_p1_q <= vld_p0;
   end

   always_ff @(posedge clk) begin
      bin_p1_q <= adr_q;
      bin_p2_q <= bin_p1_q;
   end

   assign re_p1 = wd[MW-1:bit_width];
   assign im_p1 = wd[bit_width-1:0];

   fft_mag_sq #(.bit_width(bit_width)) u_mag_sq (
      .clk    (clk),
      .reset  (reset),
      .re_p1  (re_p1),
      .im_p1  (im_p1),
      .vld_p1 (vld_p1_q),
      .mag_p2 (mag_p2),
      .vld_p2 (vld_p2)
   );

   // stage 2 -> stage 3: strict compare keeps the lowest bin on ties
   always_comb begin
      best_mag_d = best_mag_q;
      best_bin_d = best_bin_q;
      if (scan_start) begin
         best_mag_d = '0;
         best_bin_d = FIRST_BIN;
      end else if (vld_p2 && (mag_p2 > best_mag_q)) begin
         best_mag_d = mag_p2;
         best_bin_d = bin_p2_q;
      end
   end

   always_ff @(posedge clk) begin
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
   end

   always_comb begin
      peak_valid_d = report;
      peak_bin_d   = peak_bin_q;
      peak_mag_d   = peak_mag_q;
      no_signal_d  = no_signal_q;
      if (report) begin
         peak_bin_d  = best_bin_q;
         peak_mag_d  = best_mag_q;
         no_signal_d = below_thresh(best_mag_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         peak_valid_q <= 1'b0;
         peak_bin_q   <= '0;
         peak_mag_q   <= '0;
         no_signal_q  <= 1'b0;
      end else begin
         peak_valid_q <= peak_valid_d;
         peak_bin_q   <= peak_bin_d;
         peak_mag_q   <= peak_mag_d;
         no_signal_q  <= no_signal_d;
      end
   end

   assign rd_adr     = adr_q;
   assign peak_valid = peak_valid_q;
   assign peak_bin   = peak_bin_q;
   assign peak_mag   = peak_mag_q;
   assign no_signal  = no_signal_q;

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Downstream consumer of `fft_top`. When `fft_top` raises `done`, this block sweeps the positive-frequency half of the FFT result RAM, computes squared magnitude per bin and reports the dominant bin index and its magnitude to the tuner's pitch-estimation logic. While scanning it owns `fft_top`'s `rd_adr` read port, through an external mux selected by `busy`.

## Interface
Parameters:
- `bit_width`, 16: width of each real/imag component (signed, two's complement).
- `M`, 9: address width.
- `N`, 512: FFT length (2**M).
- `MIN_BIN`, 1: first bin scanned; bins below it (DC) are excluded.
- `THRESH`, 0: peak magnitudes strictly below this set `no_signal`.

Ports:
- `clk`  in  1  system clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fft_done`  in  1  `done` level from `fft_top`.
- `rd_adr`  out  M  read address to `fft_top`.
- `wd`  in  2*bit_width  `fft_top` read data: {re[31:16], im[15:0]}. Valid one cycle after `rd_adr`.
- `busy`  out  1  high while scanning; selects this block onto `fft_top`'s `rd_adr`.
- `peak_valid`  out  1  one-cycle pulse when the result is updated.
- `peak_bin`  out  M  index of the maximum-magnitude bin.
- `peak_mag`  out  2*bit_width  re²+im² of that bin, unsigned.
- `no_signal`  out  1  `peak_mag` < THRESH for the latest result.

## Operation
- States:
  - IDLE: wait for a rising edge of `fft_done`. The edge is detected against a registered copy of `fft_done`; a level held high does not retrigger.
  - SCAN: issue addresses MIN_BIN … N/2-1, one per cycle. After the last address, go to DRAIN.
  - DRAIN: wait 2 cycles for the pipeline to empty, then go to REPORT.
  - REPORT: load the outputs, pulse `peak_valid`, return to IDLE.
- Pipeline, 3 stages:
  - Stage 0: address register.
  - Stage 1: `wd` arrives.
  - Stage 2: `fft_mag_sq` registers re²+im².
  - Stage 3: compare and update `best_mag` / `best_bin`.
- Each stage carries a valid bit and the bin index alongside the data.
- Arithmetic:
  - Each square is a signed 16×16 product of at most 2^30.
  - The sum is at most 2^31 and fits a 32-bit unsigned value with no saturation.
  - (-32768)² + (-32768)² = 0x8000_0000.
- Compare rule: update only if the new magnitude is strictly greater than `best_mag`. Ties keep the lowest bin.
- `best_mag` and `best_bin` are cleared to 0 and MIN_BIN on entry to SCAN. An all-zero frame therefore reports bin MIN_BIN with magnitude 0.
- Rising edges of `fft_done` during SCAN, DRAIN or REPORT are ignored.
- Reset, including mid-scan: return to IDLE; all outputs go to 0; no `peak_valid`.

## Timing
- Reset values:
  - `rd_adr` = 0, `busy` = 0, `peak_valid` = 0, `peak_bin` = 0, `peak_mag` = 0, `no_signal` = 0.
  - The registered copy of `fft_done` resets to 0.
- Let L = N/2 − MIN_BIN, and let E0 be the edge that enters SCAN.
- At E0: `busy` goes high and `rd_adr` = MIN_BIN.
- At Ek: `rd_adr` = MIN_BIN + k, for k < L.
- The final compare occurs at E(L+2).
- At E(L+3): `peak_bin`, `peak_mag` and `no_signal` update, `peak_valid` goes high for exactly one cycle, and `busy` drops.
- Default parameters give L = 255, so `peak_valid` asserts at E258.
- Outputs hold their values until the next REPORT or reset.
- `rd_adr` holds at N/2-1 during DRAIN and returns to 0 in IDLE.

## Structure
- Shared package `fft_pkg` holds:
  - `bit_width`, `M`, `N` defaults;
  - the complex-sample typedef {re, im};
  - the state enum `peak_state_t`.
- One sub-module, `fft_mag_sq`: takes {re, im} and a valid bit, produces a registered 2*bit_width magnitude and valid, with 1-cycle latency.

## Test plan
The bench uses a behavioural RAM model with 1-cycle read latency.
- Single tone: bin 10 = (1000, 0), all other bins 0; pulse `fft_done` → `peak_bin` = 10, `peak_mag` = 1_000_000, `no_signal` = 0, `peak_valid` exactly at E258.
- Tie: bins 20 and 40 both (300, 400) → `peak_bin` = 20, `peak_mag` = 250_000.
- Extremes and last bin: bin 255 = (−32768, −32768), others ±100 → `peak_bin` = 255, `peak_mag` = 0x8000_0000.
- Excluded range: bin 0 = (30000, 0) and bin 300 = (30000, 0), bin 3 = (10, 0), rest 0; THRESH = 1000 → `peak_bin` = 3, `peak_mag` = 100, `no_signal` = 1.
- Reset mid-scan: assert `reset` low at E100 → `busy` = 0 and `rd_adr` = 0 immediately; no `peak_valid`. The next `fft_done` edge yields a correct full result.
- Retrigger immunity: hold `fft_done` high, then re-pulse it during SCAN → exactly one `peak_valid`, with correct result and timing.
